pipeline_ctrl: RTL and testbench
================================

Name: pipeline_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage RV32I pipeline.
- Drives the pipeline-register load enables and bubble-insert (flush) strobes.
- Arbitrates between three stall sources in a fixed priority: instruction-memory wait, data-memory wait, and load-use hazard. It also flushes on taken branches/jumps resolved in EX.
- Sits beside the forwarding logic: forwarding covers ALU-result hazards, and this block covers everything forwarding cannot.

Parameters:
- CNT_W, 32, width of each performance counter.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- imem_resp  in  1  instruction fetch completes this cycle
- dmem_req  in  1  MEM stage holds a load or store
- dmem_resp  in  1  data access completes this cycle
- id_rs1  in  5  rs1 of instruction in ID (rv32i_reg)
- id_rs2  in  5  rs2 of instruction in ID (rv32i_reg)
- id_use_rs1  in  1  ID instruction reads rs1
- id_use_rs2  in  1  ID instruction reads rs2
- ex_rd  in  5  rd of instruction in EX
- ex_is_load  in  1  EX instruction opcode is op_load
- ex_br_taken  in  1  EX redirects PC (taken branch, jal, jalr)
- pc_en  out  1  PC register load
- ifid_en, idex_en, exmem_en, memwb_en  out  1 each  stage-register loads
- ifid_flush, idex_flush  out  1 each  load zero control word / nop into that register
- imem_hold  out  1  IF latches fetched word into its hold register
- dmem_hold  out  1  MEM latches load data into its hold register
- stall_cnt, flush_cnt, lu_cnt  out  CNT_W each  performance counters

Behaviour:
- Interface: one clock, clk. Reset rst is asynchronous and active-high. While rst is high, every output is 0, the state is RUN, i_done=d_done=0, and all counters are 0.
- i_ok = imem_resp | i_done.
- d_ok = !dmem_req | dmem_resp | d_done.
- advance = i_ok & d_ok.
- FSM states:
  - RUN: no partial completion is held.
  - WAIT: one side completed, the other is pending.
- In RUN:
  - If advance, the cycle proceeds normally.
  - If imem_resp & !d_ok: assert imem_hold, set i_done, go to WAIT.
  - If dmem_req & dmem_resp & !i_ok: assert dmem_hold, set d_done, go to WAIT.
  - If neither side completes, stay in RUN with everything frozen.
- In WAIT:
  - On advance, clear i_done and d_done and return to RUN.
  - A response for an already-done side is ignored and cannot occur per the memory protocol.
  - If both responses arrive in the same cycle, that counts as advance, with no hold.
- Memory stall (!advance): all *_en = 0 and both flushes = 0; stall_cnt increments.
- When advance, priority is branch, then load-use, then normal.
- Branch (ex_br_taken):
  - pc_en=1, all *_en=1, ifid_flush=1, idex_flush=1.
  - flush_cnt += 1.
  - Load-use is ignored, because the ID instruction is squashed.
- Load-use (ex_is_load & ex_rd!=0 & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd))):
  - pc_en=0, ifid_en=0.
  - idex_en=1 with idex_flush=1.
  - exmem_en=1, memwb_en=1.
  - lu_cnt += 1.
  - At most one bubble is inserted: in the next cycle EX holds the bubble, so the hazard clears naturally.
- Normal: pc_en and all *_en = 1, flushes = 0.
- ex_br_taken asserted during a memory stall is held by the frozen EX register and acts on the advance cycle.
- imem_hold and dmem_hold are single-cycle pulses only.
- Counters wrap modulo 2^CNT_W and update on the clk edge following the counted cycle.
- Latency: all control outputs are combinational from state and inputs (zero-cycle). State and counters are registered.
- Reset asserted mid-WAIT discards held flags; the pipeline refetches after reset.

Decomposition:
- rv32i_types gains the following, with no new package:
  - pctrl_state_t enum {RUN, WAIT};
  - rv32i_reg reused for register indices.
- Sub-module hazard_detect is the combinational load-use comparator, output lu_hazard.
- The FSM, counters and priority mux live in pipeline_ctrl.

Test Plan:
1. Reset, then 5 cycles with imem_resp=1 and dmem_req=0 -> all *_en=1, flushes 0, all counters 0.
2. ex_is_load=1, ex_rd=5, id_rs2=5, id_use_rs2=1, imem_resp=1 -> pc_en=0, ifid_en=0, idex_flush=1, lu_cnt=1. Next cycle with ex_is_load=0 -> normal.
3. dmem_req=1 and imem_resp=1 at t0, dmem_resp=1 at t3 -> imem_hold at t0, WAIT for t1–t2, advance at t3, stall_cnt=3.
4. dmem_resp at t0, imem_resp at t2 -> dmem_hold at t0, d_done held, advance at t2.
5. ex_br_taken=1 together with a load-use match -> both flushes 1, pc_en=1, flush_cnt=1, lu_cnt unchanged.
6. rst pulsed while in WAIT with i_done=1 -> outputs 0 immediately (async), state RUN, counters 0.

Source files
------------

// File: rtl/rv32i_types.sv
// rv32i_types: shared RV32I types, including the pipeline controller FSM states
package rv32i_types;
   typedef logic [4:0] rv32i_reg;
   typedef enum logic {RUN, WAIT} pctrl_state_t;
endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// hazard_detect: flags a load in EX whose rd feeds a source register read in ID
module hazard_detect (
   input  logic       ex_is_load,
   input  logic [4:0] ex_rd,
   input  logic [4:0] id_rs1,
   input  logic [4:0] id_rs2,
   input  logic       id_use_rs1,
   input  logic       id_use_rs2,
   output logic       lu_hazard
);
   // x0 never carries a real dependency, so rd==0 is excluded
   always_comb
      lu_hazard = ex_is_load & (ex_rd != 5'd0) &
                  ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));
endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: stall/flush sequencer for the 5-stage pipeline with perf counters
module pipeline_ctrl
   import rv32i_types::*;
#(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             imem_resp,
   input  logic             dmem_req,
   input  logic             dmem_resp,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   input  logic             id_use_rs1,
   input  logic             id_use_rs2,
   input  logic [4:0]       ex_rd,
   input  logic             ex_is_load,
   input  logic             ex_br_taken,
   output logic             pc_en,
   output logic             ifid_en,
   output logic             idex_en,
   output logic             exmem_en,
   output logic             memwb_en,
   output logic             ifid_flush,
   output logic             idex_flush,
   output logic             imem_hold,
   output logic             dmem_hold,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt,
   output logic [CNT_W-1:0] lu_cnt
);
   pctrl_state_t     state_q, state_d;
   logic             i_done_q, i_done_d, d_done_q, d_done_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d, lu_cnt_q, lu_cnt_d;
   logic             lu_hazard, i_ok, d_ok, advance, br, lu;

   hazard_detect u_hazard (
      .ex_is_load (ex_is_load),
      .ex_rd      (ex_rd),
      .id_rs1     (id_rs1),
      .id_rs2     (id_rs2),
      .id_use_rs1 (id_use_rs1),
      .id_use_rs2 (id_use_rs2),
      .lu_hazard  (lu_hazard)
   );

   // A side that already completed is remembered so its response is not needed again
   always_comb begin
      i_ok      = imem_resp | i_done_q;
      d_ok      = !dmem_req | dmem_resp | d_done_q;
      advance   = !rst & i_ok & d_ok;
      br        = advance & ex_br_taken;
      lu        = advance & !ex_br_taken & lu_hazard;
      imem_hold = !rst & imem_resp & !i_done_q & !d_ok;
      dmem_hold = !rst & dmem_req & dmem_resp & !d_done_q & !i_ok;
      i_done_d  = !advance & (i_done_q | imem_hold);
      d_done_d  = !advance & (d_done_q | dmem_hold);
      state_d   = state_q;
      if (advance)
         state_d = RUN;
      else if (imem_hold | dmem_hold)
         state_d = WAIT;
   end

   // Priority mux: stall freezes everything, branch squashes, load-use bubbles EX
   always_comb begin
      pc_en       = advance & !lu;
      ifid_en     = advance & !lu;
      idex_en     = advance;
      exmem_en    = advance;
      memwb_en    = advance;
      ifid_flush  = br;
      idex_flush  = br | lu;
      stall_cnt_d = stall_cnt_q + CNT_W'(!advance);
      flush_cnt_d = flush_cnt_q + CNT_W'(br);
      lu_cnt_d    = lu_cnt_q + CNT_W'(lu);
   end

   // State, completion flags and counters; async reset drops any held completion
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= RUN;
         i_done_q    <= 1'b0;
         d_done_q    <= 1'b0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
         lu_cnt_q    <= '0;
      end else begin
         state_q     <= state_d;
         i_done_q    <= i_done_d;
         d_done_q    <= d_done_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
         lu_cnt_q    <= lu_cnt_d;
      end
   end

   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;
   assign lu_cnt    = lu_cnt_q;
endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: directed per-cycle vector table plus an async reset sequence
module tb_pipeline_ctrl;
   logic        clk = 1'b0, rst = 1'b1;
   logic        imem_resp = 0, dmem_req = 0, dmem_resp = 0;
   logic [4:0]  id_rs1 = 0, id_rs2 = 0, ex_rd = 0;
   logic        id_use_rs1 = 0, id_use_rs2 = 0, ex_is_load = 0, ex_br_taken = 0;
   logic        pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush;
   logic        imem_hold, dmem_hold;
   logic [31:0] stall_cnt, flush_cnt, lu_cnt;
   int          passed = 0, total = 0;

   localparam logic [8:0] NORM = 9'b111110000;
   localparam logic [8:0] STAL = 9'b000000000;
   localparam logic [8:0] LU   = 9'b001110100;
   localparam logic [8:0] BR   = 9'b111111100;
   localparam logic [8:0] IH   = 9'b000000010;
   localparam logic [8:0] DH   = 9'b000000001;

   typedef struct {
      logic       ir, dq, dr;
      logic [4:0] rs1, rs2, rd;
      logic       u1, u2, ld, br;
      logic [8:0] ctl;
      int         st, fl, lc;
   } vec_t;

   vec_t vecs[$];

   pipeline_ctrl #(.CNT_W(32)) dut (
      .clk(clk), .rst(rst), .imem_resp(imem_resp), .dmem_req(dmem_req), .dmem_resp(dmem_resp),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
      .ex_rd(ex_rd), .ex_is_load(ex_is_load), .ex_br_taken(ex_br_taken),
      .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en), .memwb_en(memwb_en),
      .ifid_flush(ifid_flush), .idex_flush(idex_flush), .imem_hold(imem_hold), .dmem_hold(dmem_hold),
      .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .lu_cnt(lu_cnt)
   );

   always #5 clk = ~clk;

   function automatic logic [8:0] ctl_now();
      return {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, imem_hold, dmem_hold};
   endfunction

   task automatic chk_ctl(input string name, input logic [8:0] exp);
      total++;
      if (ctl_now() === exp) passed++;
      else $display("FAIL %s ctl got=%b want=%b", name, ctl_now(), exp);
   endtask

   task automatic chk_cnt(input string name, input int st, input int fl, input int lc);
      total++;
      if (stall_cnt === 32'(st) && flush_cnt === 32'(fl) && lu_cnt === 32'(lc)) passed++;
      else $display("FAIL %s cnt got=%0d/%0d/%0d want=%0d/%0d/%0d", name,
                    stall_cnt, flush_cnt, lu_cnt, st, fl, lc);
   endtask

   task automatic drive(input vec_t v);
      imem_resp = v.ir; dmem_req = v.dq; dmem_resp = v.dr;
      id_rs1 = v.rs1; id_rs2 = v.rs2; ex_rd = v.rd;
      id_use_rs1 = v.u1; id_use_rs2 = v.u2; ex_is_load = v.ld; ex_br_taken = v.br;
   endtask

   initial begin
      //                ir dq dr rs1 rs2 rd u1 u2 ld br ctl   st fl lc
      for (int i = 0; i < 5; i++)
         vecs.push_back('{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, NORM, 0, 0, 0});
      vecs.push_back('{1, 0, 0, 0, 5, 5, 0, 1, 1, 0, LU,   0, 0, 1});
      vecs.push_back('{1, 0, 0, 0, 5, 5, 0, 1, 0, 0, NORM, 0, 0, 1});
      vecs.push_back('{1, 0, 0, 0, 0, 0, 1, 0, 1, 0, NORM, 0, 0, 1});
      vecs.push_back('{1, 0, 0, 7, 0, 7, 0, 0, 1, 0, NORM, 0, 0, 1});
      vecs.push_back('{1, 0, 0, 3, 0, 3, 1, 0, 1, 0, LU,   0, 0, 2});
      vecs.push_back('{1, 1, 0, 0, 0, 0, 0, 0, 0, 0, IH,   1, 0, 2});
      vecs.push_back('{0, 1, 0, 0, 0, 0, 0, 0, 0, 0, STAL, 2, 0, 2});
      vecs.push_back('{0, 1, 0, 0, 0, 0, 0, 0, 0, 0, STAL, 3, 0, 2});
      vecs.push_back('{0, 1, 1, 0, 0, 0, 0, 0, 0, 0, NORM, 3, 0, 2});
      vecs.push_back('{0, 1, 1, 0, 0, 0, 0, 0, 0, 0, DH,   4, 0, 2});
      vecs.push_back('{0, 1, 0, 0, 0, 0, 0, 0, 0, 0, STAL, 5, 0, 2});
      vecs.push_back('{1, 1, 0, 0, 0, 0, 0, 0, 0, 0, NORM, 5, 0, 2});
      vecs.push_back('{0, 0, 0, 0, 4, 4, 0, 1, 1, 1, STAL, 6, 0, 2});
      vecs.push_back('{1, 0, 0, 0, 4, 4, 0, 1, 1, 1, BR,   6, 1, 2});
      vecs.push_back('{1, 1, 1, 0, 0, 0, 0, 0, 0, 0, NORM, 6, 1, 2});
      vecs.push_back('{1, 1, 0, 0, 0, 0, 0, 0, 0, 0, IH,   7, 1, 2});

      imem_resp = 1;
      #1 chk_ctl("reset_ctl", STAL);
      chk_cnt("reset_cnt", 0, 0, 0);
      @(negedge clk) rst = 0;

      foreach (vecs[i]) begin
         if (i != 0) @(negedge clk);
         drive(vecs[i]);
         #1 chk_ctl($sformatf("vec%0d", i), vecs[i].ctl);
         @(posedge clk);
         #1 chk_cnt($sformatf("vec%0d", i), vecs[i].st, vecs[i].fl, vecs[i].lc);
      end

      // Now in WAIT with i_done set; pulse reset away from any clock edge
      #2 rst = 1;
      imem_resp = 1; dmem_req = 0;
      #1 chk_ctl("async_rst_ctl", STAL);
      chk_cnt("async_rst_cnt", 0, 0, 0);
      @(negedge clk) rst = 0;
      imem_resp = 1; dmem_req = 1; dmem_resp = 0;
      #1 chk_ctl("post_rst_ihold", IH);
      @(posedge clk);
      #1 chk_cnt("post_rst_cnt", 1, 0, 0);
      @(negedge clk) imem_resp = 0; dmem_resp = 1;
      #1 chk_ctl("post_rst_adv", NORM);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
